// File: rtl/seq_info_buf.sv
// Meta-info FIFO that pairs each stored entry with a beat count and retires the head
// entry once its last beat has been completed by the sequential consumer.
module seq_info_buf #(
  parameter int DEPTH  = 4,
  parameter int META_W = 32,
  parameter int NB_W   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         meta_valid_i,
  output logic                         meta_ready_o,
  input  logic [META_W-1:0]            meta_i,
  input  logic [NB_W-1:0]              meta_nb_i,
  output logic                         info_valid_o,
  output logic [META_W-1:0]            info_o,
  input  logic                         beat_valid_i,
  output logic                         beat_ready_o,
  output logic [NB_W-1:0]              beat_cnt_o,
  output logic                         last_beat_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [META_W-1:0] r_meta [DEPTH];
  logic [NB_W-1:0]   r_nb   [DEPTH];
  logic [PW-1:0]     r_wrPtr;
  logic [PW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_count;
  logic [NB_W-1:0]   r_beatCnt;

  logic w_notEmpty;
  logic w_headLast;
  logic w_push;
  logic w_beat;
  logic w_pop;

  // Status comes only from registered state, so a push never bypasses to the head.
  assign w_notEmpty = (r_count != '0);
  assign w_headLast = (r_beatCnt == r_nb[r_rdPtr]);
  assign w_push     = meta_valid_i && meta_ready_o;
  assign w_beat     = beat_valid_i && w_notEmpty;
  assign w_pop      = w_beat && w_headLast;

  assign meta_ready_o = (r_count < C_DEPTH);
  assign info_valid_o = w_notEmpty;
  assign beat_ready_o = w_notEmpty;
  assign info_o       = r_meta[r_rdPtr];
  assign beat_cnt_o   = r_beatCnt;
  assign last_beat_o  = w_notEmpty && w_headLast;
  assign count_o      = r_count;

  // Flush wins over push and pop; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_beatCnt <= '0;
    end else if (flush_i) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_beatCnt <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)       r_beatCnt <= '0;
      else if (w_beat) r_beatCnt <= r_beatCnt + NB_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_meta[r_wrPtr] <= meta_i;
      r_nb[r_wrPtr]   <= meta_nb_i;
    end
  end

endmodule

// File: tb/tb_seq_info_buf.sv
// Directed bench for seq_info_buf: a queue-based model is compared every cycle,
// and literal expectations pin the model at the interesting points.
module tb_seq_info_buf;

  localparam int DEPTH  = 4;
  localparam int META_W = 32;
  localparam int NB_W   = 8;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              metaValid;
  logic              metaReady;
  logic [META_W-1:0] meta;
  logic [NB_W-1:0]   metaNb;
  logic              infoValid;
  logic [META_W-1:0] info;
  logic              beatValid;
  logic              beatReady;
  logic [NB_W-1:0]   beatCnt;
  logic              lastBeat;
  logic [CW-1:0]     count;

  int total = 0;
  int bad   = 0;

  seq_info_buf #(.DEPTH(DEPTH), .META_W(META_W), .NB_W(NB_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .meta_valid_i (metaValid),
    .meta_ready_o (metaReady),
    .meta_i       (meta),
    .meta_nb_i    (metaNb),
    .info_valid_o (infoValid),
    .info_o       (info),
    .beat_valid_i (beatValid),
    .beat_ready_o (beatReady),
    .beat_cnt_o   (beatCnt),
    .last_beat_o  (lastBeat),
    .count_o      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [META_W-1:0] meta;
    logic [NB_W-1:0]   nb;
  } entry_t;

  entry_t mq[$];
  int     mBc = 0;

  // Model: a plain queue of entries and a beat counter for the head.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mBc = 0;
    end else if (flush) begin
      mq.delete();
      mBc = 0;
    end else begin
      bit     doPush;
      entry_t e;
      doPush = metaValid && (mq.size() < DEPTH);
      e.meta = meta;
      e.nb   = metaNb;
      if (beatValid && mq.size() > 0) begin
        if (mBc == int'(mq[0].nb)) begin
          void'(mq.pop_front());
          mBc = 0;
        end else begin
          mBc = mBc + 1;
        end
      end
      if (doPush) mq.push_back(e);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit mValid;
    mValid = (mq.size() != 0);
    checkOutput("meta_ready", 64'(metaReady), 64'(mq.size() < DEPTH));
    checkOutput("info_valid", 64'(infoValid), 64'(mValid));
    checkOutput("beat_ready", 64'(beatReady), 64'(mValid));
    checkOutput("count", 64'(count), 64'(mq.size()));
    checkOutput("beat_cnt", 64'(beatCnt), 64'(mBc));
    checkOutput("last_beat", 64'(lastBeat), 64'(mValid && (mBc == int'(mq[0].nb))));
    if (mValid) checkOutput("info", 64'(info), 64'(mq[0].meta));
  end

  task automatic applyStimulus(input logic mv, input logic [META_W-1:0] m, input logic [NB_W-1:0] nb,
                               input logic bv, input logic fl);
    metaValid = mv;
    meta      = m;
    metaNb    = nb;
    beatValid = bv;
    flush     = fl;
    @(posedge clk);
    #2;
    metaValid = 1'b0;
    meta      = '0;
    metaNb    = '0;
    beatValid = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    metaValid = 1'b0;
    meta      = '0;
    metaNb    = '0;
    beatValid = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("rst_meta_ready", 64'(metaReady), 64'd1);
    checkOutput("rst_info_valid", 64'(infoValid), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Single-beat entry: visible one cycle after push, retired by one beat.
    applyStimulus(1'b1, 32'hAAAA_0001, 8'd0, 1'b0, 1'b0);
    checkOutput("A_valid", 64'(infoValid), 64'd1);
    checkOutput("A_last", 64'(lastBeat), 64'd1);
    checkOutput("A_info", 64'(info), 64'hAAAA_0001);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("A_count_after", 64'(count), 64'd0);
    checkOutput("A_valid_after", 64'(infoValid), 64'd0);

    // Three-beat entry.
    applyStimulus(1'b1, 32'hBBBB_0002, 8'd2, 1'b0, 1'b0);
    checkOutput("B_cnt0", 64'(beatCnt), 64'd0);
    checkOutput("B_last0", 64'(lastBeat), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("B_cnt1", 64'(beatCnt), 64'd1);
    checkOutput("B_last1", 64'(lastBeat), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("B_cnt2", 64'(beatCnt), 64'd2);
    checkOutput("B_last2", 64'(lastBeat), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("B_count_after", 64'(count), 64'd0);
    checkOutput("B_cnt_after", 64'(beatCnt), 64'd0);

    // Fill to capacity, then hold a fifth offer until a pop frees a slot.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 32'hE000_0000 + 32'(i), 8'd1, 1'b0, 1'b0);
    checkOutput("full_count", 64'(count), 64'd4);
    checkOutput("full_ready", 64'(metaReady), 64'd0);
    applyStimulus(1'b1, 32'hE000_0004, 8'd1, 1'b0, 1'b0);
    checkOutput("held_count", 64'(count), 64'd4);
    applyStimulus(1'b1, 32'hE000_0004, 8'd1, 1'b1, 1'b0);
    checkOutput("held_cnt1", 64'(beatCnt), 64'd1);
    applyStimulus(1'b1, 32'hE000_0004, 8'd1, 1'b1, 1'b0);
    checkOutput("popped_count", 64'(count), 64'd3);
    checkOutput("popped_ready", 64'(metaReady), 64'd1);
    checkOutput("popped_info", 64'(info), 64'hE000_0001);
    applyStimulus(1'b1, 32'hE000_0004, 8'd1, 1'b0, 1'b0);
    checkOutput("accepted_count", 64'(count), 64'd4);

    // Drain to two entries (E3, E4).
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("drain_count", 64'(count), 64'd2);
    checkOutput("drain_info", 64'(info), 64'hE000_0003);

    // Simultaneous push and final-beat pop, twice so both pointers pass index 3.
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hF000_0005, 8'd1, 1'b1, 1'b0);
    checkOutput("swap1_count", 64'(count), 64'd2);
    checkOutput("swap1_info", 64'(info), 64'hE000_0004);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hF000_0006, 8'd3, 1'b1, 1'b0);
    checkOutput("swap2_count", 64'(count), 64'd2);
    checkOutput("swap2_info", 64'(info), 64'hF000_0005);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("wrap_info", 64'(info), 64'hF000_0006);

    // Flush with three entries, mid-entry, and a concurrent push.
    applyStimulus(1'b1, 32'h1111_0007, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1111_0008, 8'd0, 1'b1, 1'b0);
    checkOutput("preflush_count", 64'(count), 64'd3);
    checkOutput("preflush_cnt", 64'(beatCnt), 64'd1);
    applyStimulus(1'b1, 32'h1111_0009, 8'd0, 1'b1, 1'b1);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_cnt", 64'(beatCnt), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("flush_dropped", 64'(count), 64'd0);
    checkOutput("empty_beat_cnt", 64'(beatCnt), 64'd0);

    // Asynchronous reset in the middle of an entry.
    applyStimulus(1'b1, 32'h2222_000A, 8'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("prerst_cnt", 64'(beatCnt), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_ready", 64'(metaReady), 64'd1);
    checkOutput("arst_valid", 64'(infoValid), 64'd0);
    checkOutput("arst_bready", 64'(beatReady), 64'd0);
    checkOutput("arst_last", 64'(lastBeat), 64'd0);
    checkOutput("arst_count", 64'(count), 64'd0);
    checkOutput("arst_cnt", 64'(beatCnt), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("postrst_count", 64'(count), 64'd0);
    applyStimulus(1'b1, 32'h3333_000B, 8'd0, 1'b0, 1'b0);
    checkOutput("postrst_info", 64'(info), 64'h3333_000B);
    checkOutput("postrst_last", 64'(lastBeat), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("final_count", 64'(count), 64'd0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_info_buf.md
SEQ_INFO_BUF -- requirements
Module: seq_info_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered meta entries (power of two, >=2).
REQ-002 SHALL have parameter META_W, default 32, meaning width of one meta-info word.
REQ-003 SHALL have parameter NB_W, default 8, meaning width of the per-entry beat count.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port flush_i, input, 1, meaning synchronous clear of all entries and the beat counter.
REQ-007 SHALL have port meta_valid_i, input, 1, meaning a meta entry is offered by the broadcast stage.
REQ-008 SHALL have port meta_ready_o, output, 1, meaning the buffer accepts the offered entry.
REQ-009 SHALL have port meta_i, input, META_W, meaning meta-info payload.
REQ-010 SHALL have port meta_nb_i, input, NB_W, meaning beats in the entry minus one (0 = 1 beat).
REQ-011 SHALL have port info_valid_o, output, 1, meaning a head entry is available.
REQ-012 SHALL have port info_o, output, META_W, meaning payload of the head entry.
REQ-013 SHALL have port beat_valid_i, input, 1, meaning the sequential consumer completes one beat of the head entry.
REQ-014 SHALL have port beat_ready_o, output, 1, meaning a beat completion is accepted.
REQ-015 SHALL have port beat_cnt_o, output, NB_W, meaning beats already completed for the head entry.
REQ-016 SHALL have port last_beat_o, output, 1, meaning the next accepted beat retires the head entry.
REQ-017 SHALL have port count_o, output, $clog2(DEPTH+1), meaning number of occupied entries.

Function
REQ-018 SHALL store entries in FIFO order in a DEPTH-entry array with read/write pointers wrapping from DEPTH-1 to 0.
REQ-019 SHALL drive meta_ready_o = (count_o < DEPTH), independent of beat_valid_i (no pop-to-push bypass).
REQ-020 SHALL push {meta_i, meta_nb_i} at the write pointer when meta_valid_i && meta_ready_o.
REQ-021 SHALL drive info_valid_o = beat_ready_o = (count_o != 0); info_o is the head payload, 0 when empty is not required.
REQ-022 SHALL make a pushed entry visible at the head no earlier than the cycle after the push (no input-to-output bypass).
REQ-023 SHALL, on beat_valid_i && beat_ready_o with beat_cnt_o != head nb, increment beat_cnt_o by 1.
REQ-024 SHALL, on beat_valid_i && beat_ready_o with beat_cnt_o == head nb, pop the head and clear beat_cnt_o to 0 in the same edge.
REQ-025 SHALL drive last_beat_o = info_valid_o && (beat_cnt_o == head nb).
REQ-026 SHALL ignore beat_valid_i while empty (no counter change, no pointer change).
REQ-027 SHALL keep count_o unchanged on a simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-028 SHALL give flush_i priority over push and pop: pointers, count_o and beat_cnt_o cleared at the next edge; a concurrent push is dropped.
REQ-029 SHALL hold meta_ready_o high during flush only if count_o < DEPTH, the dropped push being the upstream's responsibility.

Reset
REQ-030 SHALL, while rst_ni is low, asynchronously force pointers, count_o and beat_cnt_o to 0, giving meta_ready_o=1, info_valid_o=0, beat_ready_o=0, last_beat_o=0.
REQ-031 SHALL discard all stored entries on reset assertion mid-operation, with no beat or pop pending after release.
REQ-032 SHALL resume normal operation on the first rising edge after rst_ni deasserts.

Verification
REQ-033 SHALL pass: push A(nb=0) at cycle 0 -> info_valid_o=1, last_beat_o=1 at cycle 1; beat at cycle 1 -> count_o=0 at cycle 2.
REQ-034 SHALL pass: push B(nb=2), three beats -> beat_cnt_o 0,1,2 then pop; last_beat_o high only when beat_cnt_o=2.
REQ-035 SHALL pass: push 4 entries with no beats -> meta_ready_o=0, count_o=4; 5th offer held until a pop, then accepted next cycle.
REQ-036 SHALL pass: at count_o=2, simultaneous push and final-beat pop -> count_o stays 2, write and read pointers both advance, wrap correct past index 3.
REQ-037 SHALL pass: flush_i with count_o=3, beat_cnt_o=1 and concurrent push -> count_o=0, beat_cnt_o=0, push dropped.
REQ-038 SHALL pass: rst_ni low for one cycle mid-entry (beat_cnt_o=1) -> all outputs at reset values immediately, empty after release.
